wb_pwm_fader: RTL and testbench

WB_PWM_FADER -- requirements
Module: wb_pwm_fader

---
 rtl/wb_pwm_fader.sv | 150 +++++++++++++++
 tb/tb_wb_pwm_fader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_pwm_fader.sv
// Wishbone-controlled fader: each prescaler tick sweeps every channel, moving its duty
// one step toward its target and pushing each change to the PWM block over a WB master port.
module wb_pwm_fader #(
  parameter int BITS     = 4,
  parameter int CHANNELS = 3,
  parameter int PRE_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic        m_stall_i
);

  localparam logic [31:0]     MAX_W = 32'(1) << (BITS - 1);
  localparam logic [BITS-1:0] MAX_B = MAX_W[BITS-1:0];
  localparam logic [2:0]      LAST  = 3'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REQ, WAIT} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          idx_reg, idx_next;
  logic                pending_reg;
  logic [PRE_BITS-1:0] presc_reg, period_reg;
  logic [BITS-1:0]     target_reg  [CHANNELS];
  logic [BITS-1:0]     current_reg [CHANNELS];

  logic            wb_req, period_wr, tick, step_en, is_last;
  logic [BITS-1:0] cur_sel, tgt_sel, cur_new, wr_target;
  logic [31:0]     rd_data;

  assign wb_stall_o = 1'b0;
  assign wb_req     = wb_cyc_i & wb_stb_i;
  assign period_wr  = wb_req & wb_we_i & (wb_adr_i == 32'd16);
  assign tick       = (presc_reg == period_reg);
  assign wr_target  = (wb_dat_i > MAX_W) ? MAX_B : wb_dat_i[BITS-1:0];
  assign is_last    = (idx_reg == LAST);

  assign m_cyc_o = (state_reg == REQ) || (state_reg == WAIT);
  assign m_stb_o = (state_reg == REQ);
  assign m_we_o  = (state_reg == REQ);

  // Channel select by comparison keeps the 3-bit index independent of CHANNELS.
  always_comb begin
    cur_sel = '0;
    tgt_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_reg == 3'(i)) begin
        cur_sel = current_reg[i];
        tgt_sel = target_reg[i];
      end
    end
  end

  assign step_en = (state_reg == SCAN) && (cur_sel != tgt_sel);
  assign cur_new = (cur_sel < tgt_sel) ? cur_sel + BITS'(1) : cur_sel - BITS'(1);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wb_adr_i == 32'(i))     rd_data = 32'(target_reg[i]);
      if (wb_adr_i == 32'(8 + i)) rd_data = 32'(current_reg[i]);
    end
    if (wb_adr_i == 32'd16) rd_data = 32'(period_reg);
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: if (pending_reg) begin
        state_next = SCAN;
        idx_next   = '0;
      end
      SCAN: begin
        if (step_en)      state_next = REQ;
        else if (is_last) state_next = IDLE;
        else              idx_next   = idx_reg + 3'd1;
      end
      REQ, WAIT: begin
        if (m_ack_i) begin
          if (is_last) state_next = IDLE;
          else begin
            state_next = SCAN;
            idx_next   = idx_reg + 3'd1;
          end
        end else if (state_reg == REQ && !m_stall_i) begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pending_reg <= 1'b0;
      presc_reg   <= '0;
      period_reg  <= '0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      // A tick always wins, so a sweep start and a new tick in one cycle leave one sweep queued.
      if (tick)                   pending_reg <= 1'b1;
      else if (state_reg == IDLE) pending_reg <= 1'b0;
      if (period_wr || tick) presc_reg <= '0;
      else                   presc_reg <= presc_reg + PRE_BITS'(1);
      if (period_wr) period_reg <= wb_dat_i[PRE_BITS-1:0];
      if (step_en) begin
        m_adr_o <= 32'(idx_reg);
        m_dat_o <= 32'(cur_new);
      end
      wb_ack_o <= wb_req;
      if (wb_req) wb_dat_o <= rd_data;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          target_reg[gi]  <= '0;
          current_reg[gi] <= '0;
        end else begin
          if (wb_req && wb_we_i && (wb_adr_i == 32'(gi))) target_reg[gi] <= wr_target;
          if (step_en && (idx_reg == 3'(gi)))             current_reg[gi] <= cur_new;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Directed bench for wb_pwm_fader (BITS=4, CHANNELS=3): register map, fading sweeps,
// stall handling, idle sweeps and reset in the middle of a transfer.
module tb_wb_pwm_fader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [31:0] wb_dat;
  logic        wb_ack, wb_stall;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic        m_ack = 1'b0, m_stall = 1'b0;

  wb_pwm_fader #(.BITS(4), .CHANNELS(3), .PRE_BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(wb_dat), .wb_ack_o(wb_ack),
    .wb_stall_o(wb_stall), .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_ack_i(m_ack), .m_stall_i(m_stall)
  );

  int total = 0, bad = 0;
  int xfer_n = 0, cyc_cnt = 0, stall_req = 0, stall_used = 0, unstable = 0;
  logic [31:0] xfer_adr [256];
  logic [31:0] xfer_dat [256];
  bit          ack_due = 1'b0, have_ref = 1'b0;
  logic [31:0] ref_adr = '0, ref_dat = '0;

  // Model of the PWM block: optional stall, ack one cycle after acceptance, transfer log.
  always @(negedge clk) begin
    m_ack   = ack_due;
    ack_due = 1'b0;
    if (m_cyc) cyc_cnt++;
    if (m_stb && stall_used < stall_req) begin
      if (have_ref && (m_adr != ref_adr || m_dat != ref_dat)) unstable++;
      ref_adr  = m_adr;
      ref_dat  = m_dat;
      have_ref = 1'b1;
      m_stall  = 1'b1;
      stall_used++;
    end else begin
      m_stall = 1'b0;
      if (m_stb) begin
        if (have_ref && (m_adr != ref_adr || m_dat != ref_dat)) unstable++;
        have_ref = 1'b0;
        if (xfer_n < 256) begin
          xfer_adr[xfer_n] = m_adr;
          xfer_dat[xfer_n] = m_dat;
        end
        xfer_n++;
        ack_due = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("write_ack", {31'b0, wb_ack}, 32'd1);
    $display("write adr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    check("read_ack", {31'b0, wb_ack}, 32'd1);
    check(tag, wb_dat, exp);
    $display("read  adr=0x%0h data=0x%0h expected=0x%0h", a, wb_dat, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int s0;
    int c0;
    bit found;

    // Reset state
    #1;
    check("rst_ack", {31'b0, wb_ack}, 32'd0);
    check("rst_dat", wb_dat, 32'd0);
    check("rst_mcyc", {31'b0, m_cyc}, 32'd0);
    check("rst_mstb", {31'b0, m_stb}, 32'd0);
    check("rst_madr", m_adr, 32'd0);
    check("rst_mdat", m_dat, 32'd0);
    check("stall_const", {31'b0, wb_stall}, 32'd0);
    wait_cycles(3);
    rst = 1'b0;
    wb_read_check("period_rst", 32'd16, 32'd0);
    wb_read_check("target0_rst", 32'd0, 32'd0);
    wb_read_check("current1_rst", 32'd9, 32'd0);
    @(negedge clk);
    check("ack_drops", {31'b0, wb_ack}, 32'd0);

    // Period 3, target0=2: two writes to adr 0 with data 1 then 2, then nothing more
    base = xfer_n;
    wb_write(32'd16, 32'd3);
    wb_write(32'd0, 32'd2);
    wait_cycles(60);
    check("fade0_count", 32'(xfer_n - base), 32'd2);
    check("fade0_adr_a", xfer_adr[base], 32'd0);
    check("fade0_dat_a", xfer_dat[base], 32'd1);
    check("fade0_adr_b", xfer_adr[base + 1], 32'd0);
    check("fade0_dat_b", xfer_dat[base + 1], 32'd2);
    wait_cycles(30);
    check("fade0_quiet", 32'(xfer_n - base), 32'd2);
    wb_read_check("current0", 32'd8, 32'd2);
    wb_read_check("period_rb", 32'd16, 32'd3);

    // Clamp: target1=15 reads back 8, current1 climbs 1..8 then stops
    base = xfer_n;
    wb_write(32'd1, 32'd15);
    wb_read_check("target1_clamp", 32'd1, 32'd8);
    wait_cycles(150);
    check("fade1_count", 32'(xfer_n - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("fade1_adr", xfer_adr[base + k], 32'd1);
      check("fade1_dat", xfer_dat[base + k], 32'(k + 1));
    end
    wb_read_check("current1_max", 32'd9, 32'd8);
    wb_write(32'd1, 32'd9);
    wb_read_check("target1_9", 32'd1, 32'd8);
    wb_write(32'd1, 32'hFFFF_FFFF);
    wb_read_check("target1_big", 32'd1, 32'd8);
    wb_write(32'd1, 32'd8);
    wb_read_check("target1_8", 32'd1, 32'd8);

    // Unmapped addresses: write ignored, read zero, full-width decode
    wb_write(32'd17, 32'd5);
    wb_read_check("adr17", 32'd17, 32'd0);
    wb_read_check("adr3", 32'd3, 32'd0);
    wb_write(32'h0001_0000, 32'd7);
    wb_read_check("alias_adr", 32'h0001_0000, 32'd0);
    wb_read_check("target0_kept", 32'd0, 32'd2);
    wb_write(32'h0001_0010, 32'd9);
    wb_read_check("period_kept", 32'd16, 32'd3);

    // Downward fade: current2 to 5, then target 3 gives data 4 then 3 on adr 2
    wb_write(32'd2, 32'd5);
    wait_cycles(100);
    wb_read_check("current2_5", 32'd10, 32'd5);
    base = xfer_n;
    wb_write(32'd2, 32'd3);
    wait_cycles(60);
    check("down_count", 32'(xfer_n - base), 32'd2);
    check("down_adr_a", xfer_adr[base], 32'd2);
    check("down_dat_a", xfer_dat[base], 32'd4);
    check("down_adr_b", xfer_adr[base + 1], 32'd2);
    check("down_dat_b", xfer_dat[base + 1], 32'd3);
    wb_read_check("current2_3", 32'd10, 32'd3);

    // Stall for 10 cycles on one transfer; ticks during it coalesce
    base = xfer_n;
    s0 = stall_used;
    c0 = unstable;
    stall_req = stall_used + 10;
    wb_write(32'd0, 32'd3);
    wait_cycles(80);
    check("stall_cycles", 32'(stall_used - s0), 32'd10);
    check("stall_stable", 32'(unstable - c0), 32'd0);
    check("stall_count", 32'(xfer_n - base), 32'd1);
    check("stall_adr", xfer_adr[base], 32'd0);
    check("stall_dat", xfer_dat[base], 32'd3);
    wb_read_check("current0_3", 32'd8, 32'd3);

    // Every channel at target, ticks every cycle: no master cycle at all
    wb_write(32'd16, 32'd0);
    c0 = cyc_cnt;
    wait_cycles(40);
    check("idle_no_cyc", 32'(cyc_cnt - c0), 32'd0);

    // Reset while waiting for an ack
    wb_write(32'd2, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_cyc && !m_stb) found = 1'b1;
    end
    check("wait_reached", {31'b0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_cyc", {31'b0, m_cyc}, 32'd0);
    check("rst_mid_stb", {31'b0, m_stb}, 32'd0);
    check("rst_mid_dat", m_dat, 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    c0 = cyc_cnt;
    base = xfer_n;
    wait_cycles(30);
    check("post_rst_cyc", 32'(cyc_cnt - c0), 32'd0);
    check("post_rst_xfer", 32'(xfer_n - base), 32'd0);
    wb_read_check("post_cur2", 32'd10, 32'd0);
    wb_read_check("post_tgt2", 32'd2, 32'd0);
    wb_read_check("post_cur1", 32'd9, 32'd0);
    wb_read_check("post_tgt1", 32'd1, 32'd0);
    wb_read_check("post_period", 32'd16, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
